ecc_rx_checker: RTL and testbench
=================================

# ecc_rx_checker

Pipelined SECDED (39,32) receive-side checker and corrector for the ECC-protected datapath. Codewords arrive from a channel or memory read port over a valid/ready stream. The block computes the syndrome, corrects single-bit errors and flags double-bit errors. It returns corrected words downstream with per-word status and keeps saturating error statistics for software.

## Interface
Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each codeword
- CNT_W, 16, width of each error statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input codeword valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  32  received data bits
- in_ecc  in  7  received check bits; ecc[5:0] Hamming, ecc[6] overall parity
- in_tag  in  TAG_W  sideband tag, passed through unchanged
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  32  corrected data
- out_ecc  out  7  corrected check bits
- out_tag  out  TAG_W  tag of this word
- out_single  out  1  single error detected and corrected
- out_double  out  1  uncorrectable error detected; out_data/out_ecc equal the raw input
- cnt_single  out  CNT_W  saturating count of delivered single-error words
- cnt_double  out  CNT_W  saturating count of delivered double-error words
- cnt_clr  in  1  synchronous clear of both counters
- log_valid, log_syndrome[6:0], log_tag[TAG_W-1:0], log_clr: outputs/input present only with ECC_ERR_LOG_EN (see Configuration)

## Operation
- Code layout: Hamming positions 1..38. Check bits ecc[0..5] sit at positions 1, 2, 4, 8, 16, 32. Data bits d[0..31] fill the remaining positions 3, 5, 6, 7, 9, … 38 in ascending order. ecc[6] makes the XOR of all 39 bits zero.
- Stage 1 registers the codeword, the tag and:
  - s[5:0] = recomputed Hamming bits XOR ecc[5:0]
  - p = XOR of all 39 received bits
- Stage 2 classifies the word:
  - s==0, p==0: clean; output equals input.
  - p==1, s<=38: single error. Flip the bit at position s; s==0 means ecc[6] is flipped. Assert out_single.
  - p==1, s>38: treated as uncorrectable. Assert out_double; no flip.
  - p==0, s!=0: double error. Assert out_double; no flip.
- out_single and out_double are never both 1.
- Counters increment only on output handshake (out_valid && out_ready) of a flagged word.
  - Saturate at all-ones; no wrap.
  - cnt_clr in the same cycle as an increment wins: the result is 0.
- Ordering is strictly in-order; no word is dropped or duplicated.

## Timing
- Two register stages.
  - Latency: a word accepted in cycle N is presented at out_valid in cycle N+2 when out_ready is held high.
  - Throughput: one word per cycle.
- Stall rules:
  - Stage 2 holds while out_valid && !out_ready.
  - Stage 1 advances when stage 2 is empty or draining.
  - in_ready = !s1_valid || s1_advance, combinational from out_ready and stage state.
- Handshake obligations:
  - out_* payload is stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
- Reset (asynchronous, any cycle, including mid-transfer):
  - Both stages are emptied: out_valid=0.
  - in_ready=1 from the first cycle after reset release.
  - out_data, out_ecc, out_tag = 0; out_single = out_double = 0.
  - cnt_single = cnt_double = 0.
  - log_valid = 0, log_syndrome = 0, log_tag = 0.
- Simultaneous accept and deliver in one cycle with a full pipeline is legal and sustains full rate.

## Configuration
- ECC_ERR_LOG_EN defined: a first-error capture register is compiled in.
  - On the first handshake of a flagged word while log_valid==0, it captures {p, s} into log_syndrome and the tag into log_tag, and sets log_valid.
  - The capture holds until log_clr is pulsed; log_clr has priority over capture in the same cycle.
- ECC_ERR_LOG_EN undefined: log_* ports and logic are absent; all other behaviour is identical.

## Test plan
- Clean stream: 100 back-to-back words, in_data=i, ecc valid, out_ready=1 -> outputs equal inputs two cycles later, no flags, counters 0.
- Single error: word 0xDEADBEEF with data bit 0 (position 3) flipped -> out_data=0xDEADBEEF, out_single=1, cnt_single=1; repeat for ecc[6] flipped -> out_ecc corrected.
- Double error: flip positions 3 and 5 -> out_double=1, out_data equals the raw corrupted input, cnt_double=1.
- Backpressure: out_ready low for 5 cycles mid-stream -> in_ready falls after 2 words are held, payload stable, no loss or reordering after release.
- Saturation and clear: CNT_W=2, 5 single-error words -> cnt_single=3. Assert cnt_clr together with a flagged handshake -> 0.
- Reset mid-stream with full pipeline -> out_valid=0 immediately, counters 0; with ECC_ERR_LOG_EN, log_valid=0 and the first post-reset error is captured.

Source files
------------

// File: rtl/ecc_rx_checker.sv
// Two-stage SECDED (39,32) receive checker: syndrome in stage 1, correction/classification in stage 2.
// Optional first-error capture register compiled in with `define ECC_ERR_LOG_EN.
module ecc_rx_checker #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [6:0]       in_ecc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [6:0]       out_ecc,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_single,
  output logic             out_double,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
`ifdef ECC_ERR_LOG_EN
  output logic             log_valid,
  output logic [6:0]       log_syndrome,
  output logic [TAG_W-1:0] log_tag,
  input  logic             log_clr,
`endif
  input  logic             cnt_clr
);

  localparam int DATA_W = 32;
  localparam int CW_W   = 39;

  // Codeword bit n is Hamming position n; bit 0 carries the overall parity ecc[6].
  function automatic logic [CW_W-1:0] pack_cw(input logic [DATA_W-1:0] d, input logic [6:0] e);
    logic [CW_W-1:0] cw;
    logic [4:0]      k;
    logic [2:0]      c;
    cw    = '0;
    cw[0] = e[6];
    k     = '0;
    c     = '0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        cw[6'(pos)] = e[c];
        c = c + 3'd1;
      end else begin
        cw[6'(pos)] = d[k];
        k = k + 5'd1;
      end
    end
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] cw_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    logic [4:0]        k;
    d = '0;
    k = '0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[6'(pos)];
        k = k + 5'd1;
      end
    end
    return d;
  endfunction

  function automatic logic [6:0] cw_ecc(input logic [CW_W-1:0] cw);
    return {cw[0], cw[32], cw[16], cw[8], cw[4], cw[2], cw[1]};
  endfunction

  // XOR of the positions of all set bits: recomputed Hamming bits XOR received check bits.
  function automatic logic [5:0] calc_syn(input logic [CW_W-1:0] cw);
    logic [5:0] s;
    s = '0;
    for (int pos = 1; pos < CW_W; pos++)
      if (cw[6'(pos)]) s = s ^ 6'(pos);
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic              vld_p1, vld_p2;
  logic [CW_W-1:0]   cw_p1;
  logic [TAG_W-1:0]  tag_p1, tag_p2;
  logic [5:0]        syn_p1;
  logic              par_p1;
  logic [DATA_W-1:0] data_p2;
  logic [6:0]        ecc_p2;
  logic              single_p2, double_p2;
  logic              adv_p2, accept, hs;
  logic              single_c, double_c;
  logic [CW_W-1:0]   cw_in, fix_cw;

  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign accept   = in_valid && in_ready;
  assign hs       = vld_p2 && out_ready;
  assign cw_in    = pack_cw(in_data, in_ecc);

  // Stage 1: register codeword with its syndrome and overall parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      cw_p1  <= '0;
      tag_p1 <= '0;
      syn_p1 <= '0;
      par_p1 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (accept) begin
        cw_p1  <= cw_in;
        tag_p1 <= in_tag;
        syn_p1 <= calc_syn(cw_in);
        par_p1 <= ^cw_in;
      end
    end
  end

  always_comb begin
    single_c = par_p1 && (syn_p1 <= 6'd38);
    double_c = par_p1 ? (syn_p1 > 6'd38) : (syn_p1 != 6'd0);
    fix_cw   = cw_p1;
    if (single_c) fix_cw = cw_p1 ^ (CW_W'(1) << syn_p1);
  end

`ifdef ECC_ERR_LOG_EN
  logic [6:0] syn_p2;
`endif

  // Stage 2: corrected word and status, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      data_p2   <= '0;
      ecc_p2    <= '0;
      tag_p2    <= '0;
      single_p2 <= 1'b0;
      double_p2 <= 1'b0;
`ifdef ECC_ERR_LOG_EN
      syn_p2    <= '0;
`endif
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2   <= cw_data(fix_cw);
        ecc_p2    <= cw_ecc(fix_cw);
        tag_p2    <= tag_p1;
        single_p2 <= single_c;
        double_p2 <= double_c;
`ifdef ECC_ERR_LOG_EN
        syn_p2    <= {par_p1, syn_p1};
`endif
      end
    end
  end

  assign out_valid  = vld_p2;
  assign out_data   = data_p2;
  assign out_ecc    = ecc_p2;
  assign out_tag    = tag_p2;
  assign out_single = single_p2;
  assign out_double = double_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      if (hs && single_p2) cnt_single <= sat_inc(cnt_single);
      if (hs && double_p2) cnt_double <= sat_inc(cnt_double);
    end
  end

`ifdef ECC_ERR_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_valid    <= 1'b0;
      log_syndrome <= '0;
      log_tag      <= '0;
    end else if (log_clr) begin
      log_valid    <= 1'b0;
      log_syndrome <= '0;
      log_tag      <= '0;
    end else if (hs && (single_p2 || double_p2) && !log_valid) begin
      log_valid    <= 1'b1;
      log_syndrome <= syn_p2;
      log_tag      <= tag_p2;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_rx_checker.sv
// Randomized self-checking bench for ecc_rx_checker; expectations come from the injected error count.
module tb_ecc_rx_checker;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [31:0]      in_data;
  logic [6:0]       in_ecc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [6:0]       out_ecc;
  logic [TAG_W-1:0] out_tag;
  logic             out_single, out_double;
  logic [CNT_W-1:0] cnt_single, cnt_double;
  logic             cnt_clr;
`ifdef ECC_ERR_LOG_EN
  logic             log_valid;
  logic [6:0]       log_syndrome;
  logic [TAG_W-1:0] log_tag;
  logic             log_clr;
`endif

  typedef struct packed {
    logic [31:0]      data;
    logic [6:0]       ecc;
    logic [TAG_W-1:0] tag;
    logic             single;
    logic             dbl;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    m_single = 0;
  int    m_double = 0;
  int    dpos[32];
  int    cyc = 0;

  ecc_rx_checker #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ecc(in_ecc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ecc(out_ecc), .out_tag(out_tag),
    .out_single(out_single), .out_double(out_double),
    .cnt_single(cnt_single), .cnt_double(cnt_double),
`ifdef ECC_ERR_LOG_EN
    .log_valid(log_valid), .log_syndrome(log_syndrome), .log_tag(log_tag), .log_clr(log_clr),
`endif
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      word_t w;
      w.data = out_data; w.ecc = out_ecc; w.tag = out_tag;
      w.single = out_single; w.dbl = out_double;
      obs_q.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hamming bits are the XOR of the positions of all set data bits.
  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [5:0] h;
    h = '0;
    for (int i = 0; i < 32; i++)
      if (((d >> i) & 32'd1) != 0) h = h ^ 6'(dpos[i]);
    return {^{d, h}, h};
  endfunction

  // v = {ecc, data}; flips the bit living at Hamming position pos (0 = ecc[6]).
  function automatic logic [38:0] flip(input logic [38:0] v, input int pos);
    int idx;
    idx = 38;
    if (pos != 0) begin
      if ((pos & (pos - 1)) == 0) begin
        for (int j = 0; j < 6; j++) if (pos == (1 << j)) idx = 32 + j;
      end else begin
        for (int i = 0; i < 32; i++) if (dpos[i] == pos) idx = i;
      end
    end
    return v ^ (39'd1 << idx);
  endfunction

  task automatic drive_word(input logic [31:0] d, input logic [6:0] e, input logic [TAG_W-1:0] t);
    int w;
    w = 0;
    in_valid = 1; in_data = d; in_ecc = e; in_tag = t;
    @(negedge clk);
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // nf errors injected at positions pa/pb/pc; expectation follows from nf alone.
  task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t, input int nf,
                      input int pa, input int pb, input int pc);
    logic [38:0] raw;
    word_t x;
    raw = {encode(d), d};
    if (nf >= 1) raw = flip(raw, pa);
    if (nf >= 2) raw = flip(raw, pb);
    if (nf >= 3) raw = flip(raw, pc);
    x.data = (nf >= 2) ? raw[31:0] : d;
    x.ecc = (nf >= 2) ? raw[38:32] : encode(d);
    x.tag = t; x.single = (nf == 1); x.dbl = (nf >= 2);
    exp_q.push_back(x);
    if (nf == 1) m_single = (m_single < CMAX) ? m_single + 1 : CMAX;
    if (nf >= 2) m_double = (m_double < CMAX) ? m_double + 1 : CMAX;
    drive_word(raw[31:0], raw[38:32], t);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (obs_q.size() < exp_q.size() && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (obs_q.size() < exp_q.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout delivered=%0d required %0d", obs_q.size(), exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_data = '0; in_ecc = '0; in_tag = '0;
    out_ready = 1; cnt_clr = 0;
`ifdef ECC_ERR_LOG_EN
    log_clr = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if ({out_data, out_ecc, out_tag, out_single, out_double} !== '0) begin
      n_fail++; $display("FAIL rst_payload got %h/%h/%h/%b/%b want 0", out_data, out_ecc, out_tag, out_single, out_double);
    end
    n_cmp++;
    if (cnt_single !== '0 || cnt_double !== '0) begin
      n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", cnt_single, cnt_double);
    end
`ifdef ECC_ERR_LOG_EN
    n_cmp++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL rst_log_valid got %b want 0", log_valid); end
`endif
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_clean_stream();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(32'(i), TAG_W'(i), 0, 0, 0, 0);
    n_cmp++;
    if (cyc - c0 != 100) begin n_fail++; $display("FAIL clean_rate cycles=%0d want 100", cyc - c0); end
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL clean_word got %h want %h", o, x); end
    end
    n_cmp++;
    if (cnt_single !== '0 || cnt_double !== '0) begin
      n_fail++; $display("FAIL clean_counters got %0d/%0d want 0/0", cnt_single, cnt_double);
    end
  endtask

  task automatic test_single();
    send(32'hDEADBEEF, 4'h5, 1, 3, 0, 0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early out_valid=%b want 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_single !== 1'b1) begin
      n_fail++; $display("FAIL single_data valid=%b data=%h single=%b want 1/deadbeef/1", out_valid, out_data, out_single);
    end
    wait_drain();
    n_cmp++; if (cnt_single !== CNT_W'(1)) begin n_fail++; $display("FAIL single_cnt got %0d want 1", cnt_single); end
`ifdef ECC_ERR_LOG_EN
    n_cmp++;
    if (log_valid !== 1'b1 || log_syndrome !== 7'h43 || log_tag !== 4'h5) begin
      n_fail++; $display("FAIL log_first got %b/%h/%h want 1/43/5", log_valid, log_syndrome, log_tag);
    end
`endif
    send(32'h0BADF00D, 4'h6, 1, 0, 0, 0);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL single_word got %h want %h", o, x); end
    end
    n_cmp++;
    if (cnt_single !== CNT_W'(m_single)) begin n_fail++; $display("FAIL single_cnt2 got %0d want %0d", cnt_single, m_single); end
  endtask

  task automatic test_double();
    send(32'hDEADBEEF, 4'h7, 2, 3, 5, 0);
    send(32'h12345678, 4'h8, 3, 3, 4, 32);  // positions XOR to 39: odd parity, out-of-range syndrome
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL double_word got %h want %h", o, x); end
    end
    n_cmp++;
    if (cnt_double !== CNT_W'(m_double)) begin n_fail++; $display("FAIL double_cnt got %0d want %0d", cnt_double, m_double); end
  endtask

  task automatic test_backpressure();
    logic [42:0] held;
    fork
      for (int i = 0; i < 20; i++) send($urandom, TAG_W'(i), 0, 0, 0, 0);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        held = {out_data, out_ecc, out_tag};
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_cmp++;
          if (out_valid !== 1'b1 || {out_data, out_ecc, out_tag} !== held) begin
            n_fail++; $display("FAIL bp_stable got %b/%h want 1/%h", out_valid, {out_data, out_ecc, out_tag}, held);
          end
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1 out_ready = 1;
      end
    join
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL bp_word got %h want %h", o, x); end
    end
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int nf, pa, pb;
          nf = $urandom_range(0, 2);
          pa = $urandom_range(0, 38);
          pb = (pa + 1 + $urandom_range(0, 37)) % 39;
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send($urandom, TAG_W'(i), nf, pa, pb, 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL rand_word got %h want %h", o, x); end
    end
    n_cmp++;
    if (cnt_single !== CNT_W'(m_single) || cnt_double !== CNT_W'(m_double)) begin
      n_fail++; $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", cnt_single, cnt_double, m_single, m_double);
    end
  endtask

  task automatic test_saturation_clear();
    int w;
    for (int i = 0; i < 5; i++) send($urandom, TAG_W'(i), 1, $urandom_range(0, 38), 0, 0);
    wait_drain();
    n_cmp++; if (cnt_single !== CNT_W'(CMAX)) begin n_fail++; $display("FAIL sat_cnt got %0d want %0d", cnt_single, CMAX); end
    out_ready = 0;
    send(32'hCAFEF00D, 4'h9, 1, 7, 0, 0);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    out_ready = 1; cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    m_single = 0; m_double = 0;
    n_cmp++;
    if (cnt_single !== '0 || cnt_double !== '0) begin
      n_fail++; $display("FAIL clr_wins got %0d/%0d want 0/0", cnt_single, cnt_double);
    end
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL sat_word got %h want %h", o, x); end
    end
  endtask

  task automatic test_reset_midstream();
    int p;
    send($urandom, 4'h1, 2, 9, 10, 0);
    wait_drain();
    void'(exp_q.pop_front()); void'(obs_q.pop_front());
    out_ready = 0;
    send($urandom, 4'h2, 1, 6, 0, 0);
    send($urandom, 4'h3, 1, 12, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_before_rst in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || cnt_single !== '0 || cnt_double !== '0 || out_data !== '0) begin
      n_fail++; $display("FAIL async_rst got %b/%0d/%0d/%h want 0/0/0/0", out_valid, cnt_single, cnt_double, out_data);
    end
`ifdef ECC_ERR_LOG_EN
    n_cmp++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL rst_log got %b want 0", log_valid); end
`endif
    exp_q.delete(); obs_q.delete();
    m_single = 0; m_double = 0;
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_rst in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    p = dpos[$urandom_range(0, 31)];
    send($urandom, 4'hA, 1, p, 0, 0);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      word_t x, o;
      x = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL post_rst_word got %h want %h", o, x); end
    end
    n_cmp++; if (cnt_single !== CNT_W'(1)) begin n_fail++; $display("FAIL post_rst_cnt got %0d want 1", cnt_single); end
`ifdef ECC_ERR_LOG_EN
    n_cmp++;
    if (log_valid !== 1'b1 || log_syndrome !== {1'b1, 6'(p)} || log_tag !== 4'hA) begin
      n_fail++; $display("FAIL post_rst_log got %b/%h/%h want 1/%h/a", log_valid, log_syndrome, log_tag, {1'b1, 6'(p)});
    end
`endif
  endtask

  initial begin
    int k;
    k = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        dpos[k] = p;
        k++;
      end
    end
    test_reset();
    test_clean_stream();
    test_single();
    test_double();
    test_backpressure();
    test_random();
    test_saturation_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
